mpc_sample_sequencer: RTL and testbench

- Schedules acquisition of the three MPC inputs (Vpv, Ipv, Vout) from one shared, multiplexed converter interface at a fixed sample rate.
- Runs a req/valid handshake per channel, then clamps Ipv and commits a coherent sample set.
- Pulses the calculate strobe that starts the MPC datapath.
- Sits between the converter front end and the MPC core, replacing the free-running sample counter in the top level.

---
 rtl/mpc_sample_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_mpc_sample_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mpc_sample_sequencer.sv
// Sample sequencer for the MPC front end: divides i_clk into sample ticks,
// walks the shared converter through Vpv, Ipv and Vout with a req/valid
// handshake, clamps Ipv and commits a coherent set with a calculate strobe.
module mpc_sample_sequencer #(
    parameter int WORD_SIZE     = 32,
    parameter int FRAC_BITS     = 16,
    parameter int SAMPLE_DIV    = 375,
    parameter int ADC_TIMEOUT   = 64,
    parameter int IPV_MAX_INT   = 10,
    parameter int IPV_CLAMP_INT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    input  logic                 i_clear_err,
    output logic                 o_adc_req,
    output logic [1:0]           o_adc_ch,
    input  logic                 i_adc_valid,
    input  logic [WORD_SIZE-1:0] i_adc_data,
    output logic [WORD_SIZE-1:0] o_Vpv,
    output logic [WORD_SIZE-1:0] o_Ipv,
    output logic [WORD_SIZE-1:0] o_Vout,
    output logic                 o_calc_dv,
    output logic                 o_busy,
    output logic                 o_overrun,
    output logic                 o_timeout,
    output logic [15:0]          o_frame_cnt
);

    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WAIT_W = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
    localparam int INT_W  = WORD_SIZE - FRAC_BITS;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ADC_TIMEOUT - 1);
    localparam logic [INT_W-1:0]  IPV_MAX   = INT_W'(IPV_MAX_INT);
    localparam logic [INT_W-1:0]  IPV_CLAMP = INT_W'(IPV_CLAMP_INT);

    typedef enum logic [2:0] {
        IDLE,
        REQ_VPV,
        REQ_IPV,
        REQ_VOUT,
        COMMIT
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [DIV_W-1:0]      div_cnt;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  tick;
    logic                  accept;
    logic                  expire;
    logic [WORD_SIZE-1:0]  sh_vpv;
    logic [WORD_SIZE-1:0]  sh_ipv;
    logic [WORD_SIZE-1:0]  sh_vout;
    logic [WORD_SIZE-1:0]  ipv_clamped;

    // Sample tick: last cycle of each SAMPLE_DIV-long period while enabled.
    always_comb begin
        tick = i_enable && (div_cnt == DIV_LAST);
    end

    // Sample-rate divider; held at zero while disabled.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            div_cnt <= '0;
        end else if (!i_enable || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Frame state register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; valid only counts while the request is visible.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (tick) next_state = REQ_VPV;
            end
            REQ_VPV, REQ_IPV, REQ_VOUT: begin
                if (o_adc_req && i_adc_valid) begin
                    accept = 1'b1;
                    if (state == REQ_VPV)      next_state = REQ_IPV;
                    else if (state == REQ_IPV) next_state = REQ_VOUT;
                    else                       next_state = COMMIT;
                end else if (wait_cnt == WAIT_LAST) begin
                    expire     = 1'b1;
                    next_state = IDLE;
                end
            end
            COMMIT: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ipv limit on the unsigned integer field; fraction passes through.
    always_comb begin
        ipv_clamped = sh_ipv;
        if (sh_ipv[WORD_SIZE-1:FRAC_BITS] > IPV_MAX) begin
            ipv_clamped = {IPV_CLAMP, sh_ipv[FRAC_BITS-1:0]};
        end
    end

    // Handshake outputs, wait counter and shadow capture, driven from next state
    // so req/ch line up with the state they describe.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_adc_req <= 1'b0;
            o_adc_ch  <= 2'd0;
            o_busy    <= 1'b0;
            wait_cnt  <= '0;
            sh_vpv    <= '0;
            sh_ipv    <= '0;
            sh_vout   <= '0;
        end else begin
            o_busy <= (next_state != IDLE);
            case (next_state)
                REQ_VPV:  begin o_adc_req <= 1'b1; o_adc_ch <= 2'd0; end
                REQ_IPV:  begin o_adc_req <= 1'b1; o_adc_ch <= 2'd1; end
                REQ_VOUT: begin o_adc_req <= 1'b1; o_adc_ch <= 2'd2; end
                default:  begin o_adc_req <= 1'b0; o_adc_ch <= 2'd0; end
            endcase
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (o_adc_req) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (accept) begin
                case (state)
                    REQ_VPV:  sh_vpv  <= i_adc_data;
                    REQ_IPV:  sh_ipv  <= i_adc_data;
                    REQ_VOUT: sh_vout <= i_adc_data;
                    default:  ;
                endcase
            end
        end
    end

    // Commit of a complete sample set with the calculate strobe.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_Vpv       <= '0;
            o_Ipv       <= '0;
            o_Vout      <= '0;
            o_calc_dv   <= 1'b0;
            o_frame_cnt <= '0;
        end else if (state == COMMIT) begin
            o_Vpv       <= sh_vpv;
            o_Ipv       <= ipv_clamped;
            o_Vout      <= sh_vout;
            o_calc_dv   <= 1'b1;
            o_frame_cnt <= o_frame_cnt + 1'b1;
        end else begin
            o_calc_dv   <= 1'b0;
        end
    end

    // Sticky error flags; a new event in the clearing cycle wins.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_overrun <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            if (tick && state != IDLE) o_overrun <= 1'b1;
            else if (i_clear_err)      o_overrun <= 1'b0;
            if (expire)                o_timeout <= 1'b1;
            else if (i_clear_err)      o_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mpc_sample_sequencer.sv
// Bench for mpc_sample_sequencer: a behavioural ADC responder with per-channel
// delays drives the DUT; expected timing and data come from frame arithmetic.
module tb_mpc_sample_sequencer;

    localparam int S      = 375;
    localparam int S_OV   = 8;
    localparam int TMO    = 64;
    localparam int OV_DLY = 10;
    localparam int NF     = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, en, clr, req, valid, dv, busy, ovr, tmo;
    logic [1:0]  ch;
    logic [31:0] data, vpv, ipv, vout;
    logic [15:0] fcnt;

    logic        ov_en, ov_clr, ov_req, ov_valid, ov_dv, ov_busy, ov_ovr, ov_tmo;
    logic [1:0]  ov_ch;
    logic [31:0] ov_data, ov_vpv, ov_ipv, ov_vout;
    logic [15:0] ov_fcnt;

    int          tests = 0;
    int          fails = 0;
    int          n = 0;
    logic [31:0] chdata [3];
    int          dly [3];
    logic [31:0] ov_chdata [3];

    mpc_sample_sequencer u_dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_enable(en), .i_clear_err(clr),
        .o_adc_req(req), .o_adc_ch(ch), .i_adc_valid(valid), .i_adc_data(data),
        .o_Vpv(vpv), .o_Ipv(ipv), .o_Vout(vout), .o_calc_dv(dv), .o_busy(busy),
        .o_overrun(ovr), .o_timeout(tmo), .o_frame_cnt(fcnt)
    );

    mpc_sample_sequencer #(.SAMPLE_DIV(S_OV)) u_ovr (
        .i_clk(clk), .i_reset_n(reset_n), .i_enable(ov_en), .i_clear_err(ov_clr),
        .o_adc_req(ov_req), .o_adc_ch(ov_ch), .i_adc_valid(ov_valid), .i_adc_data(ov_data),
        .o_Vpv(ov_vpv), .o_Ipv(ov_ipv), .o_Vout(ov_vout), .o_calc_dv(ov_dv), .o_busy(ov_busy),
        .o_overrun(ov_ovr), .o_timeout(ov_tmo), .o_frame_cnt(ov_fcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        n++;
    endtask

    // Ipv rule: integer field above 10 becomes 1, fraction kept.
    function automatic logic [31:0] model_ipv(input logic [31:0] x);
        int unsigned ip;
        ip = x >> 16;
        if (ip > 10) return (32'd1 << 16) | (x & 32'h0000_FFFF);
        return x;
    endfunction

    // ADC model (main DUT): answers a request for channel c after dly[c] cycles.
    initial begin
        int age;
        logic pr;
        logic [1:0] pc;
        age = 0; pr = 1'b0; pc = 2'd0;
        valid = 1'b0; data = '0;
        forever begin
            @(negedge clk);
            if (req && pr && ch == pc) age++;
            else age = 0;
            pr = req; pc = ch;
            if (req && ch != 2'd3 && age >= dly[ch]) begin
                valid = 1'b1; data = chdata[ch];
            end else begin
                valid = 1'b0; data = $urandom;
            end
        end
    end

    // ADC model (overrun DUT): fixed slow response.
    initial begin
        int age;
        logic pr;
        logic [1:0] pc;
        age = 0; pr = 1'b0; pc = 2'd0;
        ov_valid = 1'b0; ov_data = '0;
        forever begin
            @(negedge clk);
            if (ov_req && pr && ov_ch == pc) age++;
            else age = 0;
            pr = ov_req; pc = ov_ch;
            if (ov_req && ov_ch != 2'd3 && age >= OV_DLY) begin
                ov_valid = 1'b1; ov_data = ov_chdata[ov_ch];
            end else begin
                ov_valid = 1'b0; ov_data = $urandom;
            end
        end
    end

    initial begin
        int pulses, last, limit, chseq, commits, cnt, exp_int;
        bit seen_dv, found;
        logic [31:0] lv, li, lo, exp_vpv, exp_ipv, exp_vout;
        logic lreq;

        reset_n = 1'b0; en = 1'b0; clr = 1'b0; ov_en = 1'b0; ov_clr = 1'b0;
        chdata = '{32'h000C_8000, 32'h000F_4000, 32'h0019_0000};
        dly = '{0, 0, 0};
        ov_chdata = '{32'h0001_2000, 32'h000F_4000, 32'h0002_8000};
        repeat (3) @(negedge clk);
        check("rst_req", req, 0);
        check("rst_ch", ch, 0);
        check("rst_busy", busy, 0);
        check("rst_dv", dv, 0);
        check("rst_fcnt", fcnt, 0);
        check("rst_vpv", vpv, 0);
        check("rst_flags", {ovr, tmo}, 0);

        // Overrun instance: ticks every 8 cycles, frames take far longer.
        reset_n = 1'b1;
        ov_en = 1'b1;
        n = 0; pulses = 0; last = 0;
        exp_int = ((3 * (OV_DLY + 1) + 1) / S_OV + 1) * S_OV;
        while (pulses < 3 && n < 400) begin
            step();
            if (ov_dv) begin
                pulses++;
                check("ov_vpv", ov_vpv, ov_chdata[0]);
                check("ov_ipv", ov_ipv, model_ipv(ov_chdata[1]));
                check("ov_vout", ov_vout, ov_chdata[2]);
                check("ov_busy", ov_busy, 0);
                check("ov_fcnt", ov_fcnt, pulses);
                if (pulses == 1) check("ov_first", n, S_OV + 4 + 3 * OV_DLY);
                else             check("ov_interval", n - last, exp_int);
                last = n;
            end
        end
        check("ov_pulses", pulses, 3);
        check("ov_overrun", ov_ovr, 1);
        check("ov_timeout", ov_tmo, 0);
        ov_en = 1'b0;

        // Main instance frames.
        en = 1'b1;
        n = 0; commits = 0;
        exp_vpv = '0; exp_ipv = '0; exp_vout = '0;
        for (int j = 0; j < NF; j++) begin
            if (j == 0) begin
                chdata = '{32'h000C_8000, 32'h000F_4000, 32'h0019_0000};
                dly = '{0, 0, 0};
            end else if (j == 1) begin
                chdata = '{$urandom, 32'h000A_4000, $urandom};
                dly = '{0, 0, 0};
            end else begin
                chdata[0] = $urandom;
                chdata[1] = {16'($urandom_range(0, 20)), 16'($urandom)};
                chdata[2] = $urandom;
                if (j == 2) dly = '{2, 2, 2};
                else        dly = '{$urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5)};
                if (j == 3) dly[1] = 1000;
            end

            if (j == 3) begin
                limit = (j + 1) * S + TMO + 20;
                seen_dv = 1'b0;
                while (!tmo && n < limit) begin
                    step();
                    if (dv) seen_dv = 1'b1;
                end
                check("tmo_time", n, (j + 1) * S + TMO + 1 + dly[0]);
                check("tmo_no_dv", 32'(seen_dv), 0);
                check("tmo_busy", busy, 0);
                check("tmo_hold_vpv", vpv, exp_vpv);
                check("tmo_hold_ipv", ipv, exp_ipv);
                check("tmo_fcnt", fcnt, commits);
                clr = 1'b1;
                step();
                clr = 1'b0;
                check("tmo_clear", tmo, 0);
            end else begin
                limit = (j + 1) * S + 40;
                chseq = 0; lv = '0; li = '0; lo = '0; lreq = 1'b1;
                while (!dv && n < limit) begin
                    step();
                    if (!dv) begin
                        lv = vpv; li = ipv; lo = vout; lreq = req;
                        if (req && (chseq == 0 || 32'(ch) + 1 != chseq % 10))
                            chseq = chseq * 10 + 32'(ch) + 1;
                    end
                end
                check("dv_time", n, (j + 1) * S + 4 + dly[0] + dly[1] + dly[2]);
                check("hold_vpv", lv, exp_vpv);
                check("hold_ipv", li, exp_ipv);
                check("hold_vout", lo, exp_vout);
                check("req_drop", lreq, 0);
                check("ch_seq", chseq, 123);
                exp_vpv  = chdata[0];
                exp_ipv  = model_ipv(chdata[1]);
                exp_vout = chdata[2];
                commits++;
                check("vpv", vpv, exp_vpv);
                check("ipv", ipv, exp_ipv);
                check("vout", vout, exp_vout);
                check("fcnt", fcnt, commits);
                step();
                check("dv_pulse", dv, 0);
            end
        end
        check("ovr_main", ovr, 0);

        // Disabled: no ticks, no activity.
        en = 1'b0;
        cnt = 0;
        repeat (2 * S) begin
            step();
            if (dv || busy) cnt++;
        end
        check("disable_idle", cnt, 0);

        // Reset while waiting on Ipv aborts the frame.
        en = 1'b1;
        dly = '{0, 20, 0};
        found = 1'b0;
        limit = n + 2 * S + 10;
        while (!found && n < limit) begin
            step();
            if (req && ch == 2'd1) found = 1'b1;
        end
        check("reach_ipv", 32'(found), 1);
        reset_n = 1'b0;
        step();
        check("abort_req", req, 0);
        check("abort_busy", busy, 0);
        check("abort_fcnt", fcnt, 0);
        check("abort_dv", dv, 0);
        reset_n = 1'b1;
        en = 1'b0;
        step();
        check("abort_idle", {busy, dv}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
